// File: rtl/qkv_proj_engine_pkg.sv
// -----------------------------------------------------------------------------
// qkv_proj_engine_pkg
//   Shared types and helpers for the Q/K/V projection engine.
//   - state_t   : controller states (IDLE, RUN, DRAIN, HOLD)
//   - PROJ_*    : projection index constants (0 = Q, 1 = K, 2 = V)
//   - acc_w()   : accumulator width that holds any N-term dot product exactly
//   - nchunk()  : number of LANES-wide chunks in one input vector
//   - addr_w()  : weight-address width (at least one bit)
// -----------------------------------------------------------------------------
package qkv_proj_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam int PROJ_Q = 0;
   localparam int PROJ_K = 1;
   localparam int PROJ_V = 2;

   // Each product needs 2*dw bits; summing n of them grows by clog2(n) bits.
   function automatic int acc_w(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic int nchunk(input int n, input int lanes);
      return n / lanes;
   endfunction

   // A single-chunk vector still gets a one-bit address port.
   function automatic int addr_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/qkv_proj_engine_dot_lane.sv
// -----------------------------------------------------------------------------
// proj_dot_lane
//   One output row of one projection: a LANES-wide signed dot product of the
//   current input chunk with that row's weight chunk, added into an ACC_W-bit
//   accumulator.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear of the accumulator (new vector)
//     en         : add this cycle's dot product into the accumulator
//     x          : LANES x DW signed input elements, lane 0 in the LSBs
//     w          : LANES x DW signed weights, lane 0 in the LSBs
//     acc        : ACC_W-bit two's-complement running sum
// -----------------------------------------------------------------------------
module proj_dot_lane #(
   parameter int DW    = 4,
   parameter int LANES = 16,
   parameter int ACC_W = 18
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [LANES*DW-1:0]   x,
   input  logic [LANES*DW-1:0]   w,
   output logic [ACC_W-1:0]      acc
);

   localparam int PW = 2 * DW;

   logic signed [PW-1:0] prod [LANES];
   logic [ACC_W-1:0]     dot;

   // NOTE: combinational logic uses blocking '=' so the running sum builds up
   // within the loop; every output gets a default first so no latch is inferred.
   always_comb begin
      dot = '0;
      for (int l = 0; l < LANES; l++) begin
         prod[l] = $signed(x[l*DW +: DW]) * $signed(w[l*DW +: DW]);
         dot     = dot + {{(ACC_W-PW){prod[l][PW-1]}}, prod[l]};
      end
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + dot;
      end
   end

endmodule

// File: rtl/qkv_proj_engine.sv
// -----------------------------------------------------------------------------
// qkv_proj_engine
//   Streams an N-element signed vector in LANES-wide chunks and computes up to
//   three projections (Q, K, V), each HEADS rows deep, as exact signed dot
//   products. Weights come from an external memory with a one-cycle read.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     start, proj_mask    : begin a vector (IDLE only); mask bit p enables proj p
//     abort               : synchronous return to IDLE from any state
//     x_valid/x_ready     : input chunk handshake, x_chunk lane 0 in the LSBs
//     w_rd_en/w_rd_addr   : weight read request for the chunk just accepted
//     w_rd_data           : weights, valid the cycle after w_rd_en;
//                           layout [proj][head][lane], lane 0 in the LSBs
//     out_valid/out_ready : result handshake
//     out_y               : results, layout [proj][head], proj 0 head 0 in LSBs
//     busy                : high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module qkv_proj_engine
   import qkv_proj_engine_pkg::*;
#(
   parameter  int N      = 768,
   parameter  int DW     = 4,
   parameter  int HEADS  = 12,
   parameter  int LANES  = 16,
   parameter  int NPROJ  = 3,
   localparam int ACC_W  = acc_w(N, DW),
   localparam int NCHUNK = nchunk(N, LANES),
   localparam int AW     = addr_w(NCHUNK)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [NPROJ-1:0]                 proj_mask,
   input  logic                             abort,
   input  logic                             x_valid,
   output logic                             x_ready,
   input  logic [LANES*DW-1:0]              x_chunk,
   output logic                             w_rd_en,
   output logic [AW-1:0]                    w_rd_addr,
   input  logic [NPROJ*HEADS*LANES*DW-1:0]  w_rd_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NPROJ*HEADS*ACC_W-1:0]     out_y,
   output logic                             busy
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (N % LANES != 0) begin : g_bad_lanes
      $error("qkv_proj_engine: N (%0d) must be a multiple of LANES (%0d)", N, LANES);
   end
   if (NPROJ < 1 || NPROJ > 3) begin : g_bad_nproj
      $error("qkv_proj_engine: NPROJ (%0d) must be 1..3", NPROJ);
   end

   // ---------------------------------------------------------------------------
   // Controller
   // ---------------------------------------------------------------------------
   state_t               state;
   logic [AW-1:0]        chunk_cnt;
   logic [NPROJ-1:0]     mask_q;
   logic                 acc_pend;   // weights for x_q arrive this cycle
   logic [LANES*DW-1:0]  x_q;

   logic transfer;
   logic last_chunk;
   logic start_go;
   logic acc_go;

   assign transfer   = x_valid & x_ready;
   assign last_chunk = (chunk_cnt == AW'(NCHUNK - 1));
   assign start_go   = (state == ST_IDLE) & start & ~abort;
   // Abort drops weight data still in flight.
   assign acc_go     = acc_pend & ~abort;

   // The read request is issued in the transfer cycle itself so the weights
   // line up with the registered chunk one cycle later; this is what gives the
   // two-cycle last-transfer-to-result latency.
   assign w_rd_en    = transfer;
   assign w_rd_addr  = chunk_cnt;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         chunk_cnt <= '0;
         mask_q    <= '0;
         acc_pend  <= 1'b0;
         x_ready   <= 1'b0;
         out_valid <= 1'b0;
      end else if (abort) begin
         state     <= ST_IDLE;
         chunk_cnt <= '0;
         acc_pend  <= 1'b0;
         x_ready   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         acc_pend <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_RUN;
                  chunk_cnt <= '0;
                  mask_q    <= proj_mask;
                  x_ready   <= 1'b1;
               end
            end
            ST_RUN: begin
               acc_pend <= transfer;
               if (transfer) begin
                  if (last_chunk) begin
                     // Counter parks on the last index; only start/abort rewind it.
                     state   <= ST_DRAIN;
                     x_ready <= 1'b0;
                  end else begin
                     chunk_cnt <= chunk_cnt + AW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               // Final accumulate happens this cycle; results are complete next.
               state     <= ST_HOLD;
               out_valid <= 1'b1;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               x_ready   <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: pure datapath register without reset: it is only consumed when
   // acc_pend is set, which itself is reset, so its power-up value never matters.
   always_ff @(posedge clk) begin
      if (transfer) begin
         x_q <= x_chunk;
      end
   end

   // ---------------------------------------------------------------------------
   // Dot-product array: one lane per (projection, head)
   // ---------------------------------------------------------------------------
   for (genvar p = 0; p < NPROJ; p++) begin : g_proj
      for (genvar h = 0; h < HEADS; h++) begin : g_head
         localparam int ROW = p * HEADS + h;

         proj_dot_lane #(
            .DW    (DW),
            .LANES (LANES),
            .ACC_W (ACC_W)
         ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start_go),
            .en    (acc_go & mask_q[p]),
            .x     (x_q),
            .w     (w_rd_data[ROW*LANES*DW +: LANES*DW]),
            .acc   (out_y[ROW*ACC_W +: ACC_W])
         );
      end
   end

endmodule
